// File: rtl/sys_mem_burst_ctrl_if.sv
// Agent port between the burst sequencer (master) and the sys_mem arbiter (slave):
// single-word requests out, wait and in-order read returns back.
interface sys_mem_burst_ctrl_if #(
    parameter int unsigned MEM_DATA_W = 32,
    parameter int unsigned MEM_ADDR_W = 27
);
    logic                  agent_wait;
    logic                  agent_wren;
    logic                  agent_rden;
    logic [MEM_ADDR_W-1:0] agent_addr;
    logic [MEM_DATA_W-1:0] agent_wdata;
    logic                  agent_rd_valid;
    logic [MEM_DATA_W-1:0] agent_rdata;

    modport master (
        input  agent_wait, agent_rd_valid, agent_rdata,
        output agent_wren, agent_rden, agent_addr, agent_wdata
    );

    modport slave (
        output agent_wait, agent_rd_valid, agent_rdata,
        input  agent_wren, agent_rden, agent_addr, agent_wdata
    );
endinterface

// File: rtl/sys_mem_burst_ctrl.sv
// Burst sequencer on one sys_mem arbiter agent port: splits a read/write burst into
// single-word requests, caps outstanding reads. SYS_MEM_BURST_CTRL_STATS_EN adds counters.
module sys_mem_burst_ctrl #(
    parameter int unsigned             LB_DATA_W        = 32,
    parameter int unsigned             LB_ADDR_W        = 8,
    parameter int unsigned             MEM_DATA_W       = 32,
    parameter int unsigned             MEM_ADDR_W       = 27,
    parameter int unsigned             MAX_BURST_LEN    = 256,
    parameter int unsigned             MAX_OUTSTANDING  = 8,
    parameter logic [LB_DATA_W-1:0]    DEFAULT_DATA_VAL = 'hdeadbabe,
    parameter int unsigned             LEN_W            = $clog2(MAX_BURST_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lb_wr_en,
    input  logic                  lb_rd_en,
    input  logic [LB_ADDR_W-1:0]  lb_addr,
    input  logic [LB_DATA_W-1:0]  lb_wr_data,
    output logic                  lb_wr_valid,
    output logic                  lb_rd_valid,
    output logic [LB_DATA_W-1:0]  lb_rd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rd,
    input  logic [MEM_ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  wr_data_valid,
    input  logic [MEM_DATA_W-1:0] wr_data,
    output logic                  wr_data_ready,
    output logic                  rd_data_valid,
    output logic [MEM_DATA_W-1:0] rd_data,
    output logic                  burst_done,
    sys_mem_burst_ctrl_if.master  agent
);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, DONE} state_t;

    state_t                state_q, state_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [OUT_W-1:0]      out_cnt_q;
    logic                  len_err_q, stray_q;
    logic                  rd_acc_c, len_err_set_c;
    logic                  ret_ok_c, stray_set_c, status_clr_c;
    logic                  unused_lb_wr_data_c;

    assign ret_ok_c            = agent.agent_rd_valid && (out_cnt_q != '0);
    assign stray_set_c         = agent.agent_rd_valid && (out_cnt_q == '0);
    assign status_clr_c        = lb_rd_en && (lb_addr == LB_ADDR_W'(0));
    assign unused_lb_wr_data_c = ^lb_wr_data;

    // Next-state and agent request generation
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        rem_d             = rem_q;
        rd_acc_c          = 1'b0;
        len_err_set_c     = 1'b0;
        wr_data_ready     = 1'b0;
        agent.agent_rden  = 1'b0;
        agent.agent_wren  = 1'b0;
        agent.agent_addr  = addr_q;
        agent.agent_wdata = wr_data;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_len > LEN_W'(MAX_BURST_LEN)) begin
                        len_err_set_c = 1'b1;
                        state_d       = DONE;
                    end else begin
                        state_d = cmd_rd ? RD_ISSUE : WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                // out_cnt only falls while a request waits, so the request holds until taken
                agent.agent_rden = (out_cnt_q < OUT_W'(MAX_OUTSTANDING));
                rd_acc_c         = agent.agent_rden && !agent.agent_wait;
                if (rd_acc_c) begin
                    addr_d = addr_q + MEM_ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (ret_ok_c && (out_cnt_q == OUT_W'(1))) state_d = DONE;
            end
            WR_ISSUE: begin
                agent.agent_wren = wr_data_valid;
                wr_data_ready    = wr_data_valid && !agent.agent_wait;
                if (wr_data_ready) begin
                    addr_d = addr_q + MEM_ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and client-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rem_q         <= '0;
            out_cnt_q     <= '0;
            cmd_ready     <= 1'b1;
            burst_done    <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            cmd_ready     <= (state_d == IDLE);
            burst_done    <= (state_d == DONE);
            rd_data_valid <= ret_ok_c;
            if (ret_ok_c) rd_data <= agent.agent_rdata;
            case ({rd_acc_c, ret_ok_c})
                2'b10:   out_cnt_q <= out_cnt_q + OUT_W'(1);
                2'b01:   out_cnt_q <= out_cnt_q - OUT_W'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

`ifdef SYS_MEM_BURST_CTRL_STATS_EN
    logic [31:0] burst_cnt_q, wait_cnt_q;
    logic        wait_evt_c;

    assign wait_evt_c = (agent.agent_rden || agent.agent_wren) && agent.agent_wait;

    // Burst count wraps; wait count saturates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (state_q == DONE) burst_cnt_q <= burst_cnt_q + 32'd1;
            if (wait_evt_c && (wait_cnt_q != '1)) wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end
`endif

    // Local bus: sticky status and register read-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_err_q   <= 1'b0;
            stray_q     <= 1'b0;
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            lb_rd_data  <= '0;
        end else begin
            len_err_q   <= len_err_set_c || (len_err_q && !status_clr_c);
            stray_q     <= stray_set_c   || (stray_q   && !status_clr_c);
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            if (lb_rd_en) begin
                case (lb_addr)
                    LB_ADDR_W'(0): lb_rd_data <= LB_DATA_W'({stray_q, len_err_q, (state_q != IDLE)});
`ifdef SYS_MEM_BURST_CTRL_STATS_EN
                    LB_ADDR_W'(1): lb_rd_data <= LB_DATA_W'(burst_cnt_q);
                    LB_ADDR_W'(2): lb_rd_data <= LB_DATA_W'(wait_cnt_q);
`endif
                    default:       lb_rd_data <= DEFAULT_DATA_VAL;
                endcase
            end
        end
    end
endmodule

// File: doc/sys_mem_burst_ctrl.md
# sys_mem_burst_ctrl

Burst sequencer that sits on one agent port of the sys_mem arbiter. It accepts a single burst command (read or write, base address, word count) from a client. It then issues the corresponding single-word agent transactions to the arbiter, honouring the arbiter's wait handshake and capping the number of outstanding reads. Read data is returned in order to the client, and a done pulse ends each burst.

## Interface
- LB_DATA_W, 32, local bus data width
- LB_ADDR_W, 8, local bus address width
- MEM_DATA_W, 32, memory word width
- MEM_ADDR_W, 27, memory word address width
- MAX_BURST_LEN, 256, max words per burst
- MAX_OUTSTANDING, 8, max issued-but-unreturned reads
- DEFAULT_DATA_VAL, 'hdeadbabe, read value for unmapped LB addresses
- LEN_W, $clog2(MAX_BURST_LEN)+1, derived, do not override
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- lb_wr_en / lb_rd_en  in  1  local bus write / read strobes
- lb_addr  in  LB_ADDR_W  local bus address
- lb_wr_data  in  LB_DATA_W  local bus write data (no writable registers)
- lb_wr_valid / lb_rd_valid  out  1  local bus acks
- lb_rd_data  out  LB_DATA_W  local bus read data
- cmd_valid  in  1  burst command request
- cmd_ready  out  1  high only in IDLE
- cmd_rd  in  1  1 = read burst, 0 = write burst
- cmd_addr  in  MEM_ADDR_W  base word address
- cmd_len  in  LEN_W  word count
- wr_data_valid  in  1  write word available (must not depend on wr_data_ready)
- wr_data  in  MEM_DATA_W  write word
- wr_data_ready  out  1  write word consumed this cycle
- rd_data_valid  out  1  read word valid; no backpressure
- rd_data  out  MEM_DATA_W  read word
- burst_done  out  1  one-cycle pulse at burst end
- agent_wait  in  1  arbiter wait
- agent_wren / agent_rden  out  1  arbiter requests
- agent_addr  out  MEM_ADDR_W  request address
- agent_wdata  out  MEM_DATA_W  request write data
- agent_rd_valid  in  1  arbiter read return
- agent_rdata  in  MEM_DATA_W  arbiter read data

## Operation
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE, DONE.
- IDLE, command accepted (cmd_valid & cmd_ready):
  - Latch addr, len and direction.
  - len 0 -> DONE.
  - len > MAX_BURST_LEN -> set len_err sticky, then DONE; nothing is issued.
  - Otherwise -> RD_ISSUE or WR_ISSUE.
- RD_ISSUE:
  - agent_rden = (out_cnt < MAX_OUTSTANDING).
  - Acceptance is agent_rden & ~agent_wait. On acceptance: addr+1, issue count+1, out_cnt+1.
  - Once asserted, a request and its address are held until accepted.
  - After the last acceptance -> RD_DRAIN.
- RD_DRAIN: when out_cnt reaches 0 via the last return -> DONE.
- Every agent_rd_valid decrements out_cnt.
  - out_cnt increments and decrements in the same cycle net to 0.
  - agent_rd_valid with out_cnt==0 is dropped (no rd_data_valid) and sets stray_rd sticky.
- WR_ISSUE:
  - agent_wren = wr_data_valid; agent_wdata = wr_data.
  - wr_data_ready = agent_wren & ~agent_wait.
  - On acceptance: addr+1. After the last acceptance -> DONE.
- DONE: burst_done=1 for one cycle -> IDLE.
- Address increment wraps modulo 2^MEM_ADDR_W; no error is flagged.
- LB register map:
  - 0x00 STATUS = {zeros, stray_rd, len_err, busy}, where busy = state!=IDLE.
  - Sticky bits clear on an LB read of 0x00, unless set again in the same cycle.
  - Other addresses return DEFAULT_DATA_VAL.
  - lb_wr_valid <= lb_wr_en; lb_rd_valid <= lb_rd_en.

## Timing
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - FSM IDLE; out_cnt and all counters 0; sticky flags 0.
- Reset mid-burst: on the next edge return to IDLE and drop all state. Reads returning afterwards count as stray.
- Command accepted at edge T: first agent_rden/agent_wren at T+1.
- Read return: agent_rd_valid at cycle R -> rd_data_valid/rd_data registered at R+1.
- Read burst end: if R is the last return, burst_done is asserted at R+1 (concurrent with the last rd_data_valid); cmd_ready=1 at R+2.
- Write burst end: last acceptance at W -> burst_done at W+1, cmd_ready at W+2.
- Zero-length or errored command: accepted at T -> burst_done at T+1.
- Peak throughput: one acceptance per cycle while agent_wait=0.
- LB read data: 1-cycle latency.

## Configuration
- SYS_MEM_BURST_CTRL_STATS_EN defined:
  - 0x01 BURST_CNT: completed bursts, 32-bit, wraps.
  - 0x02 WAIT_CNT: cycles with a request asserted and agent_wait=1, 32-bit, saturating.
  - Both registers clear on reset only.
- Not defined: counters are absent; 0x01 and 0x02 return DEFAULT_DATA_VAL.

## Test plan
- Read, addr 0x100, len 4, agent_wait=0, 2-cycle return latency -> rden at addrs 0x100..0x103 on consecutive cycles; 4 rd_data_valid in order; burst_done with the 4th word.
- Read, len 20, returns withheld -> exactly 8 accepted, then rden low until a return arrives; out_cnt never exceeds 8.
- Write, len 3, wr_data_valid gapped, agent_wait toggling -> agent_addr/agent_wdata stable across wait; wr_data_ready only on acceptance; burst_done at W+1.
- Write, addr 2^27-2, len 4 -> addresses 0x7FFFFFE, 0x7FFFFFF, 0x0, 0x1.
- cmd_len 0 and then cmd_len 257 -> no agent requests; burst_done at T+1 for each; STATUS reads 0x2, and a second read returns 0x0.
- Reset asserted mid-read with 3 outstanding -> IDLE next edge; the 3 late returns are dropped; STATUS=0x4; with STATS_EN, BURST_CNT=0.
